// File: rtl/pix_send_pkg.sv
// rtl/pix_send_pkg.sv - shared state encoding, frame constants and byte helper for pix_send
package pix_send_pkg;

    localparam int         FRAME_W      = 160;
    localparam int         FRAME_H      = 120;
    localparam int         FRAME_PIX    = 19200;
    localparam int         FRAME_ADDR_W = 15;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_HI,
        ST_LO,
        ST_CHK,
        ST_FIN
    } state_t;

    // Upper nibble of a 12-bit pixel, zero-extended into its own wire byte
    function automatic logic [7:0] pix_hi_byte(input logic [11:0] pix);
        return {4'h0, pix[11:8]};
    endfunction

endpackage

// File: rtl/pix_send_byte.sv
// rtl/pix_send_byte.sv - single-byte strobe / wait-for-done pacing toward the UART transmitter
module pix_send_byte (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_done,
    output logic       byte_done
);

    logic waiting;

    // A done pulse only completes a byte that is actually in flight; the
    // strobe cycle itself cannot be its own completion.
    assign byte_done = waiting && tx_done && !tx_valid;
    assign s_tready  = !waiting || byte_done;

    // Launch a byte with a one-cycle strobe, hold the data until the UART reports completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            waiting  <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (s_tvalid && s_tready) begin
                tx_data  <= s_tdata;
                tx_valid <= 1'b1;
                waiting  <= 1'b1;
            end else if (byte_done) begin
                waiting  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pix_send.sv
// rtl/pix_send.sv - frame sender: header, 12-bit pixels as two bytes, optional XOR checksum (PIX_SEND_CHKSUM_EN)
module pix_send
    import pix_send_pkg::*;
#(
    parameter int         PIX_NUM  = FRAME_PIX,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
    parameter int         ADDR_W   = FRAME_ADDR_W
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [11:0]       i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_done
);

    // One spare bit so the counter can represent PIX_NUM itself
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX_NUM - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    pix_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [11:0]         pix_reg;
    logic                rd_wait;
    logic                last_pix;
    logic                byte_load;
    logic [7:0]          byte_data;
    logic                byte_ready;
    logic                byte_done;
`ifdef PIX_SEND_CHKSUM_EN
    logic [7:0]          chk;
    logic                byte_is_pix;
`endif

    assign last_pix  = (pix_cnt == LAST_CNT);
    assign o_rd_addr = rd_addr;
    assign o_busy    = (state != ST_IDLE) && (state != ST_FIN);
    assign o_done    = (state == ST_FIN);

    pix_send_byte u_byte (
        .clk       (i_clk_sys),
        .rst_n     (i_rst_n),
        .s_tdata   (byte_data),
        .s_tvalid  (byte_load),
        .s_tready  (byte_ready),
        .tx_data   (o_tx_data),
        .tx_valid  (o_tx_valid),
        .tx_done   (i_tx_done),
        .byte_done (byte_done)
    );

    // Next-state decode; each byte is handed to the pacer on the transition that enters its state
    always_comb begin
        state_nxt = state;
        byte_load = 1'b0;
        byte_data = 8'h00;
`ifdef PIX_SEND_CHKSUM_EN
        byte_is_pix = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (i_start && byte_ready) begin
                    state_nxt = ST_HDR;
                    byte_load = 1'b1;
                    byte_data = HDR_BYTE;
                end
            end
            ST_HDR: begin
                if (byte_done) begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                // Second RD cycle: read data for the address driven last cycle is valid now
                if (rd_wait && byte_ready) begin
                    state_nxt = ST_HI;
                    byte_load = 1'b1;
                    byte_data = pix_hi_byte(i_rd_data);
`ifdef PIX_SEND_CHKSUM_EN
                    byte_is_pix = 1'b1;
`endif
                end
            end
            ST_HI: begin
                if (byte_done) begin
                    state_nxt = ST_LO;
                    byte_load = 1'b1;
                    byte_data = pix_reg[7:0];
`ifdef PIX_SEND_CHKSUM_EN
                    byte_is_pix = 1'b1;
`endif
                end
            end
            ST_LO: begin
                if (byte_done) begin
                    if (last_pix) begin
`ifdef PIX_SEND_CHKSUM_EN
                        state_nxt = ST_CHK;
                        byte_load = 1'b1;
                        byte_data = chk;
`else
                        state_nxt = ST_FIN;
`endif
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_CHK: begin
                if (byte_done) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus pixel counter, read address and pixel latch
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            pix_cnt <= '0;
            rd_addr <= '0;
            pix_reg <= 12'h000;
            rd_wait <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_HDR) begin
                        pix_cnt <= '0;
                        rd_addr <= '0;
                        rd_wait <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else if (state_nxt == ST_HI) begin
                        rd_wait <= 1'b0;
                        pix_reg <= i_rd_data;
                    end
                end
                ST_LO: begin
                    // Address moves together with the return to RD so the
                    // read latency is counted from RD entry.
                    if (byte_done) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (!last_pix) begin
                            rd_addr <= ADDR_W'(pix_cnt + 1'b1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIX_SEND_CHKSUM_EN
    // Running XOR of every pixel byte as it is handed to the pacer
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chk <= 8'h00;
        end else if (state == ST_IDLE && state_nxt == ST_HDR) begin
            chk <= 8'h00;
        end else if (byte_load && byte_is_pix) begin
            chk <= chk ^ byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_pix_send.sv
// tb/tb_pix_send.sv - randomized self-checking bench for pix_send against a byte-stream model
`timescale 1ns/1ps
module tb_pix_send;

    localparam int         NA    = 2;
    localparam int         NB    = 500;
    localparam int         LIMIT = 5000;
    localparam logic [7:0] HDR   = 8'hAA;
`ifdef PIX_SEND_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic clk;
    logic rst_n;

    logic        start_a, busy_a, done_a, tx_valid_a, tx_done_a;
    logic [14:0] addr_a;
    logic [11:0] rd_data_a;
    logic [7:0]  tx_data_a;

    logic        start_b, busy_b, done_b, tx_valid_b, tx_done_b;
    logic [14:0] addr_b;
    logic [11:0] rd_data_b;
    logic [7:0]  tx_data_b;

    logic [11:0] mem_a [NA];
    logic [11:0] mem_b [NB];

    pix_send #(.PIX_NUM(NA), .HDR_BYTE(HDR), .ADDR_W(15)) dut_a (
        .i_clk_sys (clk),
        .i_rst_n   (rst_n),
        .i_start   (start_a),
        .o_busy    (busy_a),
        .o_done    (done_a),
        .o_rd_addr (addr_a),
        .i_rd_data (rd_data_a),
        .o_tx_data (tx_data_a),
        .o_tx_valid(tx_valid_a),
        .i_tx_done (tx_done_a)
    );

    pix_send #(.PIX_NUM(NB), .HDR_BYTE(HDR), .ADDR_W(15)) dut_b (
        .i_clk_sys (clk),
        .i_rst_n   (rst_n),
        .i_start   (start_b),
        .o_busy    (busy_b),
        .o_done    (done_b),
        .o_rd_addr (addr_b),
        .i_rd_data (rd_data_b),
        .o_tx_data (tx_data_b),
        .o_tx_valid(tx_valid_b),
        .i_tx_done (tx_done_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // UART / frame-buffer model state for dut_a
    logic [7:0]  rx_a [$];
    int          cyc_a = 0;
    bit          pend_a = 0;
    int          wait_a = 0;
    logic [7:0]  held_a = 8'h00;
    int          lat_lo = 0, lat_hi = 0;
    bit          stray_mode = 0;
    int          viol_a = 0, unstable_a = 0, done_cnt_a = 0, busy_bad_a = 0;
    int          done_cyc_a = -1, txdone_cyc_a = -1, first_cyc_a = -1, start_cyc_a = -1;
    int          rst_strobe = 0;
    int          prev_addr_a = 0;

    initial begin
        tx_done_a = 1'b0;
        rd_data_a = 12'h000;
        forever begin
            @(negedge clk);
            cyc_a++;
            tx_done_a = 1'b0;
            rd_data_a = (prev_addr_a < NA) ? mem_a[prev_addr_a] : 12'hFFF;
            prev_addr_a = int'(addr_a);
            if (!rst_n) begin
                if (tx_valid_a) rst_strobe++;
                pend_a = 0;
            end else begin
                if (done_a) begin
                    done_cnt_a++;
                    done_cyc_a = cyc_a;
                    if (busy_a) busy_bad_a++;
                end
                if (tx_valid_a) begin
                    if (rx_a.size() == 0) first_cyc_a = cyc_a;
                    rx_a.push_back(tx_data_a);
                    if (pend_a) viol_a++;
                    pend_a = 1;
                    held_a = tx_data_a;
                    wait_a = $urandom_range(lat_hi, lat_lo);
                end else if (pend_a) begin
                    if (tx_data_a !== held_a) unstable_a++;
                    if (wait_a == 0) begin
                        tx_done_a    = 1'b1;
                        pend_a       = 0;
                        txdone_cyc_a = cyc_a;
                    end else begin
                        wait_a--;
                    end
                end else if (stray_mode && $urandom_range(2, 0) == 0) begin
                    tx_done_a = 1'b1;
                end
            end
        end
    end

    // UART / frame-buffer model state for dut_b
    logic [7:0] rx_b [$];
    bit         pend_b = 0;
    int         wait_b = 0;
    int         viol_b = 0, done_cnt_b = 0, max_addr_b = 0, oor_b = 0;
    bit         seen_b [NB];
    int         prev_addr_b = 0;

    initial begin
        tx_done_b = 1'b0;
        rd_data_b = 12'h000;
        forever begin
            @(negedge clk);
            tx_done_b = 1'b0;
            rd_data_b = (prev_addr_b < NB) ? mem_b[prev_addr_b] : 12'hFFF;
            prev_addr_b = int'(addr_b);
            if (!rst_n) begin
                pend_b = 0;
            end else begin
                if (busy_b) begin
                    if (int'(addr_b) < NB) seen_b[int'(addr_b)] = 1;
                    else oor_b++;
                    if (int'(addr_b) > max_addr_b) max_addr_b = int'(addr_b);
                end
                if (done_b) done_cnt_b++;
                if (tx_valid_b) begin
                    rx_b.push_back(tx_data_b);
                    if (pend_b) viol_b++;
                    pend_b = 1;
                    wait_b = $urandom_range(4, 0);
                end else if (pend_b) begin
                    if (wait_b == 0) begin
                        tx_done_b = 1'b1;
                        pend_b    = 0;
                    end else begin
                        wait_b--;
                    end
                end
            end
        end
    end

    // Expected wire bytes for a frame: header, then high/low byte of each pixel, then XOR of pixel bytes
    function automatic void model_bytes(input logic [11:0] px [$], output logic [7:0] q [$]);
        logic [7:0] x;
        x = 8'h00;
        q = {};
        q.push_back(HDR);
        foreach (px[i]) begin
            q.push_back(8'(int'(px[i]) / 256));
            q.push_back(8'(int'(px[i]) % 256));
        end
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        if (CHK_ON) q.push_back(x);
    endfunction

    // Index of the first differing byte, -2 on length difference, -1 when identical
    function automatic int first_diff(input logic [7:0] got [$], input logic [7:0] exp [$]);
        if (got.size() != exp.size()) return -2;
        foreach (exp[i]) if (got[i] !== exp[i]) return i;
        return -1;
    endfunction

    task automatic run_frame_a(input int lo, input int hi, input bit extra_starts, input bit stray_on,
                               output int cycles);
        rx_a.delete();
        done_cnt_a = 0; viol_a = 0; unstable_a = 0; busy_bad_a = 0;
        first_cyc_a = -1; done_cyc_a = -1; txdone_cyc_a = -1;
        lat_lo = lo; lat_hi = hi; stray_mode = stray_on;
        @(negedge clk); #1;
        start_a = 1'b1;
        start_cyc_a = cyc_a;
        @(negedge clk); #1;
        start_a = 1'b0;
        cycles = 0;
        while (done_cnt_a == 0 && cycles < LIMIT) begin
            @(negedge clk); #1;
            cycles++;
            start_a = (extra_starts && (cycles % 7 == 3)) ? 1'b1 : 1'b0;
        end
        start_a = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
        end
        stray_mode = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_a); end
        total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid_a); end
        total++; if (tx_data_a !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data_a); end
        total++; if (addr_a !== 15'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d expected 0", addr_a); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_basic();
        logic [7:0] exp [$];
        int cyc, d;
        mem_a[0] = 12'hABC; mem_a[1] = 12'h123;
        exp = '{8'hAA, 8'h0A, 8'hBC, 8'h01, 8'h23};
        if (CHK_ON) exp.push_back(8'h94);
        run_frame_a(2, 2, 0, 0, cyc);
        total++; if (cyc >= LIMIT) begin bad++; $display("FAIL basic_timeout: waited %0d cycles limit %0d", cyc, LIMIT); end
        d = first_diff(rx_a, exp);
        total++; if (d != -1) begin bad++; $display("FAIL basic_stream: diff at %0d got %p expected %p", d, rx_a, exp); end
        total++; if (done_cnt_a != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt_a); end
        total++; if (done_cyc_a - txdone_cyc_a != 1) begin bad++; $display("FAIL basic_done_latency: got %0d expected 1", done_cyc_a - txdone_cyc_a); end
        total++; if (first_cyc_a - start_cyc_a != 1) begin bad++; $display("FAIL basic_start_latency: got %0d expected 1", first_cyc_a - start_cyc_a); end
        total++; if (viol_a != 0) begin bad++; $display("FAIL basic_early_strobe: got %0d expected 0", viol_a); end
        total++; if (busy_bad_a != 0) begin bad++; $display("FAIL basic_busy_at_done: got %0d expected 0", busy_bad_a); end
    endtask

    task automatic test_random();
        logic [11:0] px [$];
        logic [7:0]  exp [$];
        int cyc, d;
        for (int f = 0; f < 4; f++) begin
            px = {};
            for (int i = 0; i < NA; i++) begin
                mem_a[i] = 12'($urandom);
                px.push_back(mem_a[i]);
            end
            model_bytes(px, exp);
            run_frame_a(0, 5, 0, 1, cyc);
            d = first_diff(rx_a, exp);
            total++; if (d != -1) begin bad++; $display("FAIL random_stream[%0d]: diff at %0d got %p expected %p", f, d, rx_a, exp); end
            total++; if (done_cnt_a != 1) begin bad++; $display("FAIL random_done_count[%0d]: got %0d expected 1", f, done_cnt_a); end
            total++; if (viol_a != 0 || unstable_a != 0) begin bad++; $display("FAIL random_handshake[%0d]: early=%0d unstable=%0d expected 0/0", f, viol_a, unstable_a); end
        end
    endtask

    task automatic test_slow_done();
        logic [11:0] px [$];
        logic [7:0]  exp [$];
        int cyc, d;
        px = {};
        for (int i = 0; i < NA; i++) begin
            mem_a[i] = 12'($urandom);
            px.push_back(mem_a[i]);
        end
        model_bytes(px, exp);
        run_frame_a(100, 100, 0, 0, cyc);
        d = first_diff(rx_a, exp);
        total++; if (d != -1) begin bad++; $display("FAIL slow_stream: diff at %0d got %p expected %p", d, rx_a, exp); end
        total++; if (viol_a != 0) begin bad++; $display("FAIL slow_early_strobe: got %0d expected 0", viol_a); end
        total++; if (unstable_a != 0) begin bad++; $display("FAIL slow_data_stable: got %0d changes expected 0", unstable_a); end
        total++; if (cyc < 100 * exp.size()) begin bad++; $display("FAIL slow_duration: got %0d cycles expected at least %0d", cyc, 100 * exp.size()); end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] px [$];
        logic [7:0]  exp [$];
        int cyc, d;
        px = {};
        for (int i = 0; i < NA; i++) begin
            mem_a[i] = 12'($urandom);
            px.push_back(mem_a[i]);
        end
        model_bytes(px, exp);
        run_frame_a(1, 4, 1, 0, cyc);
        d = first_diff(rx_a, exp);
        total++; if (d != -1) begin bad++; $display("FAIL busy_start_stream: diff at %0d got %p expected %p", d, rx_a, exp); end
        total++; if (done_cnt_a != 1) begin bad++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt_a); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] px [$];
        logic [7:0]  exp [$];
        int n, cyc, d;
        px = {};
        for (int i = 0; i < NA; i++) begin
            mem_a[i] = 12'($urandom);
            px.push_back(mem_a[i]);
        end
        rx_a.delete();
        lat_lo = 3; lat_hi = 3; stray_mode = 0; rst_strobe = 0;
        @(negedge clk); #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        n = 0;
        while (rx_a.size() < 3 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        total++; if (rx_a.size() < 3) begin bad++; $display("FAIL midrst_third_byte: got %0d bytes expected 3", rx_a.size()); end
        rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
        end
        total++; if (rst_strobe != 0) begin bad++; $display("FAIL midrst_strobes: got %0d expected 0", rst_strobe); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (addr_a !== 15'd0) begin bad++; $display("FAIL midrst_addr: got %0d expected 0", addr_a); end
        model_bytes(px, exp);
        run_frame_a(2, 2, 0, 0, cyc);
        d = first_diff(rx_a, exp);
        total++; if (d != -1) begin bad++; $display("FAIL midrst_restart_stream: diff at %0d got %p expected %p", d, rx_a, exp); end
        total++; if (rx_a.size() == 0 || rx_a[0] !== HDR) begin bad++; $display("FAIL midrst_first_byte: got %p expected first byte %h", rx_a, HDR); end
    endtask

    task automatic test_long_frame();
        logic [11:0] px [$];
        logic [7:0]  exp [$];
        int n, d, miss;
        px = {};
        for (int i = 0; i < NB; i++) begin
            mem_b[i] = 12'($urandom);
            px.push_back(mem_b[i]);
            seen_b[i] = 0;
        end
        model_bytes(px, exp);
        rx_b.delete();
        viol_b = 0; done_cnt_b = 0; max_addr_b = 0; oor_b = 0;
        @(negedge clk); #1 start_b = 1'b1;
        @(negedge clk); #1 start_b = 1'b0;
        n = 0;
        while (done_cnt_b == 0 && n < 40000) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (5) begin
            @(negedge clk); #1;
        end
        total++; if (n >= 40000) begin bad++; $display("FAIL long_timeout: waited %0d cycles", n); end
        total++; if (rx_b.size() != 2 * NB + 1 + int'(CHK_ON)) begin bad++; $display("FAIL long_strobe_count: got %0d expected %0d", rx_b.size(), 2 * NB + 1 + int'(CHK_ON)); end
        d = first_diff(rx_b, exp);
        total++; if (d != -1) begin bad++; $display("FAIL long_stream: first diff at %0d of %0d bytes", d, exp.size()); end
        miss = 0;
        foreach (seen_b[i]) if (!seen_b[i]) miss++;
        total++; if (miss != 0 || oor_b != 0 || max_addr_b != NB - 1) begin bad++; $display("FAIL long_addr_span: missing=%0d out_of_range=%0d max=%0d expected 0/0/%0d", miss, oor_b, max_addr_b, NB - 1); end
        total++; if (viol_b != 0) begin bad++; $display("FAIL long_early_strobe: got %0d expected 0", viol_b); end
        total++; if (done_cnt_b != 1) begin bad++; $display("FAIL long_done_count: got %0d expected 1", done_cnt_b); end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < NA; i++) mem_a[i] = 12'h000;
        for (int i = 0; i < NB; i++) mem_b[i] = 12'h000;
        test_reset();
        test_frame_basic();
        test_random();
        test_slow_done();
        test_start_while_busy();
        test_reset_mid();
        test_long_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
